led_pio_blink: RTL and testbench
================================

// Module: led_pio_blink
// PURPOSE
//  Avalon-MM slave output PIO driving board LEDs/GPIO; parametrised width.
//  Adds atomic bit set/clear registers and per-bit hardware blink from a programmable prescaler.
//  Sits on the system interconnect beside the other PIO slaves; out_port goes to pins.
// PARAMETERS
//  DATA_WIDTH      8   output bits, 1..32
//  RESET_VALUE     0   DATA register value after reset (DATA_WIDTH bits)
//  PRESCALE_WIDTH  24  width of PRESCALE register and counter, 1..32
// PORTS
//  clk        in   1            sole clock, rising edge
//  reset      in   1            asynchronous, active-high reset
//  address    in   3            word address
//  chipselect in   1            slave select
//  write_n    in   1            active-low write strobe
//  writedata  in   32           write data
//  readdata   out  32           read data, combinational, zero wait states
//  out_port   out  DATA_WIDTH   registered LED/GPIO drive
// BEHAVIOUR
//  Register map (wr = chipselect & ~write_n):
//   0 DATA rw; 1 BLINK_MASK rw; 2 PRESCALE rw; 3 STATUS ro, bit0 = phase;
//   4 OUTSET wo, DATA |= wd; 5 OUTCLEAR wo, DATA &= ~wd; 6,7 unmapped.
//  Reads: unused upper bits, wo and unmapped addresses read 0. Writes to ro/unmapped are ignored.
//  writedata bits >= DATA_WIDTH (>= PRESCALE_WIDTH for PRESCALE) are ignored.
//  Reset (async assert, sync release): DATA=RESET_VALUE, BLINK_MASK=0, PRESCALE=0, cnt=0,
//   phase=0, out_port=RESET_VALUE. Reset mid-blink forces this state immediately.
//  Prescaler:
//   - PRESCALE==0: cnt and phase held at 0; blinking halted.
//   - Otherwise cnt++ per clk; on cycle where cnt==PRESCALE: cnt<=0, phase<=~phase.
//   - Toggle period = PRESCALE+1 clks.
//   - A write to PRESCALE clears cnt and phase on the same edge; this has priority over a toggle.
//   - If PRESCALE is written below the current cnt, the counter is cleared anyway, so no wrap-around
//     through 2^PRESCALE_WIDTH occurs.
//  Output: out_port <= DATA_next ^ (BLINK_MASK_next & {DATA_WIDTH{phase_next}}), registered.
//   - A write at edge N is visible on out_port after edge N, i.e. one clk latency.
//   - Clearing a BLINK_MASK bit returns that pin to its DATA value on the next edge.
//  OUTSET/OUTCLEAR give race-free single-bit updates. They live at separate addresses, so they
//   cannot collide in one cycle.
// CONFIGURATION
//  LED_PIO_BLINK_EN defined:
//   - Full prescaler/blink logic as above.
//  LED_PIO_BLINK_EN undefined:
//   - BLINK_MASK, PRESCALE and STATUS read 0; writes to them are ignored.
//   - phase is constant 0; no counter is instantiated.
//   - out_port <= DATA_next; DATA/OUTSET/OUTCLEAR behaviour and latency are unchanged.
// STRUCTURE
//  Shared package led_pio_pkg:
//   - register address constants (ADDR_DATA..ADDR_OUTCLEAR)
//   - STATUS bit index constant
//  Sub-module led_pio_prescaler (PRESCALE_WIDTH):
//   - inputs clk, reset, period, clear
//   - output phase
//   - instantiated only under LED_PIO_BLINK_EN
// TESTING
//  1. Reset with RESET_VALUE=8'hA5 -> out_port=8'hA5, readdata@0=32'hA5, @1/@2/@3 = 0.
//  2. Write DATA=0x0F, OUTSET 0x30, OUTCLEAR 0x01 -> DATA reads 0x3E; out_port tracks each write
//     one clk later.
//  3. PRESCALE=3, BLINK_MASK=0x01, DATA=0 -> out_port[0] toggles every 4 clks; other bits stay 0;
//     STATUS bit0 follows.
//  4. Mid-period write PRESCALE=1 while cnt=2 -> phase=0 and cnt=0 on that edge; then toggles
//     every 2 clks.
//  5. Assert reset mid-blink -> out_port=RESET_VALUE, BLINK_MASK=0 before the next clk edge.
//  6. Build without LED_PIO_BLINK_EN: write BLINK_MASK=0xFF, PRESCALE=1 -> reads 0, out_port==DATA.

Source files
------------

// File: rtl/led_pio_pkg.sv
// -----------------------------------------------------------------------------
// led_pio_pkg
// Purpose : shared definitions for the led_pio_blink output PIO.
//           Holds the register word-address map and the STATUS bit layout.
//           Also holds a small helper that decodes the Avalon-MM write strobe.
// Contents:
//   ADDR_*            3-bit word addresses of the register map
//   STATUS_PHASE_BIT  bit position of the blink phase in STATUS
//   bus_wr()          chipselect & ~write_n
// -----------------------------------------------------------------------------
package led_pio_pkg;

    localparam logic [2:0] ADDR_DATA       = 3'd0;
    localparam logic [2:0] ADDR_BLINK_MASK = 3'd1;
    localparam logic [2:0] ADDR_PRESCALE   = 3'd2;
    localparam logic [2:0] ADDR_STATUS     = 3'd3;
    localparam logic [2:0] ADDR_OUTSET     = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR   = 3'd5;

    localparam int STATUS_PHASE_BIT = 0;

    function automatic logic bus_wr(input logic chipselect, input logic write_n);
        return chipselect & ~write_n;
    endfunction

endpackage

// File: rtl/led_pio_blink_if.sv
// -----------------------------------------------------------------------------
// led_pio_blink_if
// Purpose : Avalon-MM slave port bundle for the LED PIO.
// Signals :
//   address    [2:0]   word address
//   chipselect         slave select
//   write_n            active-low write strobe
//   writedata  [31:0]  write data
//   readdata   [31:0]  read data (combinational in the slave, zero wait states)
// Modports: master (interconnect side), slave (PIO side)
// -----------------------------------------------------------------------------
interface led_pio_blink_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/led_pio_prescaler.sv
// -----------------------------------------------------------------------------
// led_pio_prescaler
// Purpose : free-running blink phase generator.
//           The counter advances once per clk; when it reaches period it
//           returns to 0 and the phase flips, so the phase toggles every
//           period+1 clocks. period == 0 halts and holds everything at 0.
// Ports   :
//   clk         in   sole clock, rising edge
//   reset       in   asynchronous, active-high reset
//   period      in   PRESCALE register value
//   clear       in   PRESCALE is being written this cycle
//   phase       out  registered blink phase
//   phase_next  out  value phase takes at the coming edge, lets the parent
//                    register out_port in step with the phase flop
// -----------------------------------------------------------------------------
module led_pio_prescaler #(
    parameter int PRESCALE_WIDTH = 24
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [PRESCALE_WIDTH-1:0] period,
    input  logic                      clear,
    output logic                      phase,
    output logic                      phase_next
);

    logic [PRESCALE_WIDTH-1:0] cnt_q;
    logic [PRESCALE_WIDTH-1:0] cnt_d;
    logic                      phase_q;
    logic                      phase_d;

    // A PRESCALE write wins over a toggle on the same edge. It always
    // restarts the count, so lowering period below the current count can
    // never make the counter run all the way round through 2^PRESCALE_WIDTH.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clear || (period == '0)) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == period) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + PRESCALE_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase      = phase_q;
    assign phase_next = phase_d;

endmodule

// File: rtl/led_pio_blink.sv
// -----------------------------------------------------------------------------
// led_pio_blink
// Purpose : Avalon-MM slave output PIO for board LEDs/GPIO with atomic
//           bit set/clear and optional per-bit hardware blink.
// Register map (word addresses):
//   0 DATA        rw
//   1 BLINK_MASK  rw   (reads 0 without LED_PIO_BLINK_EN)
//   2 PRESCALE    rw   (reads 0 without LED_PIO_BLINK_EN)
//   3 STATUS      ro   bit0 = blink phase (0 without LED_PIO_BLINK_EN)
//   4 OUTSET      wo   DATA |= writedata
//   5 OUTCLEAR    wo   DATA &= ~writedata
//   6,7           unmapped, read 0, writes ignored
// Ports   :
//   clk       in   sole clock, rising edge
//   reset     in   asynchronous, active-high reset
//   bus       slave modport of led_pio_blink_if
//   out_port  out  registered LED/GPIO drive, DATA_WIDTH bits
// Build option:
//   LED_PIO_BLINK_EN  defined -> BLINK_MASK/PRESCALE/STATUS and the
//                     prescaler are built; undefined -> out_port follows DATA.
// -----------------------------------------------------------------------------
module led_pio_blink
    import led_pio_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE    = '0,
    parameter int                    PRESCALE_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    led_pio_blink_if.slave        bus,
    output logic [DATA_WIDTH-1:0] out_port
);

    logic                  wr;
    logic [31:0]           wd;
    logic [DATA_WIDTH-1:0] wd_data;
    logic                  unused_wd;

    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;
    logic [DATA_WIDTH-1:0] out_q;
    logic [DATA_WIDTH-1:0] out_d;
    logic [31:0]           rdata;

    assign wr        = bus_wr(bus.chipselect, bus.write_n);
    assign wd        = bus.writedata;
    assign wd_data   = wd[DATA_WIDTH-1:0];
    // Bits above the register widths are deliberately ignored.
    assign unused_wd = ^wd;

    always_comb begin
        data_d = data_q;
        if (wr) begin
            case (bus.address)
                ADDR_DATA:     data_d = wd_data;
                ADDR_OUTSET:   data_d = data_q | wd_data;
                ADDR_OUTCLEAR: data_d = data_q & ~wd_data;
                default:       data_d = data_q;
            endcase
        end
    end

`ifdef LED_PIO_BLINK_EN
    logic [DATA_WIDTH-1:0]     mask_q;
    logic [DATA_WIDTH-1:0]     mask_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic [PRESCALE_WIDTH-1:0] prescale_d;
    logic                      prescale_wr;
    logic                      phase;
    logic                      phase_next;

    assign prescale_wr = wr && (bus.address == ADDR_PRESCALE);

    always_comb begin
        mask_d     = mask_q;
        prescale_d = prescale_q;
        if (wr && (bus.address == ADDR_BLINK_MASK)) begin
            mask_d = wd_data;
        end
        if (prescale_wr) begin
            prescale_d = wd[PRESCALE_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q     <= '0;
            prescale_q <= '0;
        end else begin
            mask_q     <= mask_d;
            prescale_q <= prescale_d;
        end
    end

    // The prescaler counts against the current PRESCALE; the write strobe
    // restarts it so the new period starts cleanly from cnt = 0, phase = 0.
    led_pio_prescaler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_prescaler (
        .clk        (clk),
        .reset      (reset),
        .period     (prescale_q),
        .clear      (prescale_wr),
        .phase      (phase),
        .phase_next (phase_next)
    );

    // Built from next-state values so a register write reaches the pins
    // exactly one edge later, the same edge the register itself updates.
    always_comb begin
        out_d = data_d ^ (mask_d & {DATA_WIDTH{phase_next}});
    end

    always_comb begin
        rdata = '0;
        case (bus.address)
            ADDR_DATA:       rdata[DATA_WIDTH-1:0]     = data_q;
            ADDR_BLINK_MASK: rdata[DATA_WIDTH-1:0]     = mask_q;
            ADDR_PRESCALE:   rdata[PRESCALE_WIDTH-1:0] = prescale_q;
            ADDR_STATUS:     rdata[STATUS_PHASE_BIT]   = phase;
            default:         rdata = '0;
        endcase
    end
`else
    // No blink hardware; keep the parameter referenced so the interface of
    // the block is identical in both builds.
    logic [PRESCALE_WIDTH-1:0] unused_prescale_stub;
    assign unused_prescale_stub = '0;

    always_comb begin
        out_d = data_d;
    end

    always_comb begin
        rdata = '0;
        case (bus.address)
            ADDR_DATA: rdata[DATA_WIDTH-1:0] = data_q;
            default:   rdata = '0;
        endcase
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= RESET_VALUE;
            out_q  <= RESET_VALUE;
        end else begin
            data_q <= data_d;
            out_q  <= out_d;
        end
    end

    assign bus.readdata = rdata;
    assign out_port     = out_q;

endmodule

// File: tb/tb_led_pio_blink.sv
// -----------------------------------------------------------------------------
// tb_led_pio_blink
// Directed self-checking bench for led_pio_blink (DATA_WIDTH=8,
// RESET_VALUE=8'hA5, PRESCALE_WIDTH=24). Blink scenarios are compiled in
// only when LED_PIO_BLINK_EN is defined; otherwise the disabled-feature
// behaviour is checked instead.
// -----------------------------------------------------------------------------
module tb_led_pio_blink;
    import led_pio_pkg::*;

    localparam int         DW = 8;
    localparam logic [7:0] RV = 8'hA5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] out_port;
    int            n_cmp = 0;
    int            n_err = 0;

    led_pio_blink_if bus ();

    led_pio_blink #(
        .DATA_WIDTH     (DW),
        .RESET_VALUE    (RV),
        .PRESCALE_WIDTH (24)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    task automatic bus_idle();
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;
    endtask

    // Drive at negedge, commit on the posedge, return 1 time unit later.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = d;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;
    endtask

    // Combinational read at mid-cycle; no clock edge is consumed.
    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        #1;
        d = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [31:0] exp;
        bus_idle();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (out_port !== RV) begin
            n_err++;
            $display("FAIL reset_out_held: got %h expected %h", out_port, RV);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_port !== RV) begin
            n_err++;
            $display("FAIL reset_out_after_release: got %h expected %h", out_port, RV);
        end
        for (int a = 0; a < 8; a++) begin
            exp = (a == 0) ? 32'h0000_00A5 : 32'h0;
            bus_read(3'(a), rd);
            n_cmp++;
            if (rd !== exp) begin
                n_err++;
                $display("FAIL reset_read_addr%0d: got %h expected %h", a, rd, exp);
            end
        end
    endtask

    task automatic test_data_ops();
        logic [31:0] rd;
        // Latency: old value before the edge, new value after it.
        @(negedge clk);
        bus.address    = ADDR_DATA;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = 32'h0000_000F;
        #1;
        n_cmp++;
        if (out_port !== 8'hA5) begin
            n_err++;
            $display("FAIL data_before_edge: got %h expected %h", out_port, 8'hA5);
        end
        @(posedge clk);
        #1;
        bus_idle();
        n_cmp++;
        if (out_port !== 8'h0F) begin
            n_err++;
            $display("FAIL data_write: got %h expected %h", out_port, 8'h0F);
        end
        bus_write(ADDR_OUTSET, 32'h0000_0030);
        n_cmp++;
        if (out_port !== 8'h3F) begin
            n_err++;
            $display("FAIL outset: got %h expected %h", out_port, 8'h3F);
        end
        bus_write(ADDR_OUTCLEAR, 32'h0000_0001);
        n_cmp++;
        if (out_port !== 8'h3E) begin
            n_err++;
            $display("FAIL outclear: got %h expected %h", out_port, 8'h3E);
        end
        bus_read(ADDR_DATA, rd);
        n_cmp++;
        if (rd !== 32'h0000_003E) begin
            n_err++;
            $display("FAIL data_readback: got %h expected %h", rd, 32'h3E);
        end
        // Upper writedata bits are ignored.
        bus_write(ADDR_DATA, 32'hFFFF_FF5A);
        bus_read(ADDR_DATA, rd);
        n_cmp++;
        if ((out_port !== 8'h5A) || (rd !== 32'h0000_005A)) begin
            n_err++;
            $display("FAIL data_wide_write: got out %h rd %h expected 5a/0000005a", out_port, rd);
        end
        bus_write(ADDR_OUTSET, 32'hFFFF_FF00);
        bus_write(ADDR_OUTCLEAR, 32'h0000_0100);
        n_cmp++;
        if (out_port !== 8'h5A) begin
            n_err++;
            $display("FAIL set_clear_upper_bits: got %h expected %h", out_port, 8'h5A);
        end
        bus_write(ADDR_OUTSET, 32'h0000_0081);
        n_cmp++;
        if (out_port !== 8'hDB) begin
            n_err++;
            $display("FAIL outset_multi: got %h expected %h", out_port, 8'hDB);
        end
        bus_write(ADDR_OUTCLEAR, 32'h0000_0042);
        n_cmp++;
        if (out_port !== 8'h99) begin
            n_err++;
            $display("FAIL outclear_multi: got %h expected %h", out_port, 8'h99);
        end
        // Writes to STATUS and unmapped addresses are ignored.
        bus_write(ADDR_STATUS, 32'hFFFF_FFFF);
        bus_write(3'd6, 32'hFFFF_FFFF);
        bus_write(3'd7, 32'h0000_0000);
        bus_read(ADDR_DATA, rd);
        n_cmp++;
        if ((out_port !== 8'h99) || (rd !== 32'h0000_0099)) begin
            n_err++;
            $display("FAIL ignored_writes: got out %h rd %h expected 99/00000099", out_port, rd);
        end
        // write_n low without chipselect must not write.
        @(negedge clk);
        bus.address    = ADDR_DATA;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b0;
        bus.writedata  = 32'h0000_0000;
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_port !== 8'h99) begin
            n_err++;
            $display("FAIL no_chipselect: got %h expected %h", out_port, 8'h99);
        end
        // Chipselect with write_n high is a read, not a write.
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        @(posedge clk);
        #1;
        bus_idle();
        n_cmp++;
        if (out_port !== 8'h99) begin
            n_err++;
            $display("FAIL read_strobe_no_write: got %h expected %h", out_port, 8'h99);
        end
    endtask

`ifdef LED_PIO_BLINK_EN
    task automatic test_blink();
        logic [31:0] rd;
        logic        ph;
        bus_write(ADDR_DATA, 32'h0);
        bus_write(ADDR_PRESCALE, 32'd3);          // edge k = 0
        bus_read(ADDR_PRESCALE, rd);
        n_cmp++;
        if (rd !== 32'd3) begin
            n_err++;
            $display("FAIL prescale_readback: got %h expected %h", rd, 32'd3);
        end
        bus_write(ADDR_BLINK_MASK, 32'h0000_0001); // edge k = 1
        n_cmp++;
        if (out_port !== 8'h00) begin
            n_err++;
            $display("FAIL blink_k1: got %h expected %h", out_port, 8'h00);
        end
        bus.address    = ADDR_STATUS;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        // Phase flips on edges 4, 8, 12 after the PRESCALE write.
        for (int k = 2; k <= 13; k++) begin
            @(posedge clk);
            #1;
            ph = ((k / 4) % 2) == 1;
            n_cmp++;
            if ((out_port !== {7'b0, ph}) || (bus.readdata !== {31'b0, ph})) begin
                n_err++;
                $display("FAIL blink_k%0d: got out %h status %h expected phase %0d",
                         k, out_port, bus.readdata, ph);
            end
        end
        bus_idle();
    endtask

    task automatic test_prescale_rewrite();
        logic [31:0] rd;
        logic        ph;
        @(posedge clk);                            // edge k = 14, cnt = 2
        #1;
        bus_write(ADDR_PRESCALE, 32'd1);           // edge k = 15, phase was 1
        bus_read(ADDR_STATUS, rd);
        n_cmp++;
        if ((out_port !== 8'h00) || (rd !== 32'h0)) begin
            n_err++;
            $display("FAIL prescale_rewrite_clear: got out %h status %h expected 00/0", out_port, rd);
        end
        bus.address    = ADDR_STATUS;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            @(posedge clk);
            #1;
            ph = ((j / 2) % 2) == 1;
            n_cmp++;
            if ((out_port !== {7'b0, ph}) || (bus.readdata !== {31'b0, ph})) begin
                n_err++;
                $display("FAIL rewrite_j%0d: got out %h status %h expected phase %0d",
                         j, out_port, bus.readdata, ph);
            end
        end
        bus_idle();
        // j = 7: phase is 1, but clearing the mask returns the pin to DATA.
        bus_write(ADDR_BLINK_MASK, 32'h0);
        bus_read(ADDR_STATUS, rd);
        n_cmp++;
        if ((out_port !== 8'h00) || (rd !== 32'h1)) begin
            n_err++;
            $display("FAIL mask_clear: got out %h status %h expected 00/1", out_port, rd);
        end
    endtask

    task automatic test_reset_mid_blink();
        logic [31:0] rd;
        bus_write(ADDR_BLINK_MASK, 32'hFFFF_FF0F);
        bus_read(ADDR_BLINK_MASK, rd);
        n_cmp++;
        if (rd !== 32'h0000_000F) begin
            n_err++;
            $display("FAIL mask_wide_write: got %h expected %h", rd, 32'h0F);
        end
        bus_write(ADDR_PRESCALE, 32'hFFFF_FFFF);
        bus_read(ADDR_PRESCALE, rd);
        n_cmp++;
        if (rd !== 32'h00FF_FFFF) begin
            n_err++;
            $display("FAIL prescale_wide_write: got %h expected %h", rd, 32'h00FF_FFFF);
        end
        bus_write(ADDR_DATA, 32'h0000_000F);
        bus_write(ADDR_PRESCALE, 32'd1);           // edge j = 0, phase 0
        @(posedge clk);                            // j = 1
        @(posedge clk);                            // j = 2, phase 1
        #1;
        n_cmp++;
        if (out_port !== 8'h00) begin
            n_err++;
            $display("FAIL blink_before_reset: got %h expected %h", out_port, 8'h00);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (out_port !== RV) begin
            n_err++;
            $display("FAIL reset_mid_blink_out: got %h expected %h", out_port, RV);
        end
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        for (int a = 0; a < 4; a++) begin
            bus.address = 3'(a);
            #1;
            n_cmp++;
            if (bus.readdata !== ((a == 0) ? 32'h0000_00A5 : 32'h0)) begin
                n_err++;
                $display("FAIL reset_mid_blink_read%0d: got %h", a, bus.readdata);
            end
        end
        bus_idle();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (out_port !== RV) begin
            n_err++;
            $display("FAIL halted_after_reset: got %h expected %h", out_port, RV);
        end
    endtask
`else
    task automatic test_blink_disabled();
        logic [31:0] rd;
        bus_write(ADDR_BLINK_MASK, 32'h0000_00FF);
        bus_write(ADDR_PRESCALE, 32'd1);
        for (int a = 1; a <= 3; a++) begin
            bus_read(3'(a), rd);
            n_cmp++;
            if (rd !== 32'h0) begin
                n_err++;
                $display("FAIL disabled_read%0d: got %h expected 0", a, rd);
            end
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (out_port !== 8'h99) begin
                n_err++;
                $display("FAIL disabled_out_c%0d: got %h expected %h", c, out_port, 8'h99);
            end
        end
    endtask

    task automatic test_async_reset();
        bus_write(ADDR_DATA, 32'h0000_003C);
        n_cmp++;
        if (out_port !== 8'h3C) begin
            n_err++;
            $display("FAIL pre_reset_data: got %h expected %h", out_port, 8'h3C);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (out_port !== RV) begin
            n_err++;
            $display("FAIL async_reset_out: got %h expected %h", out_port, RV);
        end
        bus.address    = ADDR_DATA;
        bus.chipselect = 1'b1;
        #1;
        n_cmp++;
        if (bus.readdata !== 32'h0000_00A5) begin
            n_err++;
            $display("FAIL async_reset_data: got %h expected %h", bus.readdata, 32'hA5);
        end
        bus_idle();
        @(negedge clk);
        reset = 1'b0;
    endtask
`endif

    initial begin
        bus_idle();
        test_reset();
        test_data_ops();
`ifdef LED_PIO_BLINK_EN
        test_blink();
        test_prescale_rewrite();
        test_reset_mid_blink();
`else
        test_blink_disabled();
        test_async_reset();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
